// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM states and line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_baud_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module tx_baud_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic rollover_flag
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign rollover_flag = enable && (cnt_q == LAST);

  // Restart at zero on rollover so the count never runs past its terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = rollover_flag ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops bytes from a FWFT FIFO and sends start, LSB-first data, stop.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 emptyTx,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_deq,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 timer_clear, timer_en, bit_end;

  tx_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk          (clk),
    .reset        (reset),
    .clear        (timer_clear),
    .enable       (timer_en),
    .rollover_flag(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    tx_deq      = 1'b0;
    tx_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!emptyTx) state_d = LOAD;
      end
      LOAD: begin
        tx_deq      = 1'b1;
        shift_d     = tx_data;
        bit_cnt_d   = '0;
        timer_clear = 1'b1;
        state_d     = START;
      end
      START: begin
        timer_en = 1'b1;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        timer_en = 1'b1;
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        timer_en = 1'b1;
        // The FIFO is only consulted here, so mid-frame emptyTx changes are ignored.
        if (bit_end) begin
          tx_done = 1'b1;
          state_d = emptyTx ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so it switches on the same edge as the FSM.
  always_comb begin
    serial_d = IDLE_LEVEL;
    case (state_d)
      START:   serial_d = START_BIT;
      DATA:    serial_d = shift_d[0];
      STOP:    serial_d = STOP_BIT;
      default: serial_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model plus frame-level scoreboard, and a default-rate instance.
module tb_uart_tx_ctrl;

  localparam int C = 4;
  localparam int F = 10 * C;

  logic       clk;
  logic       reset;
  logic       emptyTx;
  logic [7:0] tx_data;
  logic       tx_deq, serial_out, tx_busy, tx_done;

  logic       emptyTx2;
  logic [7:0] tx_data2;
  logic       tx_deq2, serial_out2, tx_busy2, tx_done2;

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .emptyTx(emptyTx), .tx_data(tx_data),
    .tx_deq(tx_deq), .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_ctrl dut10 (
    .clk(clk), .reset(reset), .emptyTx(emptyTx2), .tx_data(tx_data2),
    .tx_deq(tx_deq2), .serial_out(serial_out2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  logic deq_mid = 1'b0;
  logic expect_load = 1'b0;
  int   deq_cnt = 0, done_cnt = 0, busy_cycles = 0, busy_run = 0, last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Line level for bit slot k of a frame carrying b: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic void refresh();
    emptyTx = (fifo_q.size() == 0);
    tx_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    refresh();
  endtask

  // FIFO model: the pop seen during LOAD takes effect just after the edge that ends LOAD.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (deq_mid && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin
    deq_mid = tx_deq && !reset;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (tx_deq)  deq_cnt++;
      if (tx_done) done_cnt++;
      if (tx_busy) begin
        busy_run++;
        busy_cycles++;
      end else if (busy_run != 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
    end
  end

  // Monitor: every cycle is either idle, LOAD, or one of the F cycles of a frame.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset) begin
        expect_load = 1'b0;
        continue;
      end
      check("deq_timing", tx_deq, expect_load);
      if (!tx_deq) begin
        check("idle_line", serial_out, 1'b1);
        check("idle_busy", tx_busy, 1'b0);
        check("idle_done", tx_done, 1'b0);
        expect_load = !emptyTx;
      end else begin
        check("load_nonempty", emptyTx, 1'b0);
        check("load_line", serial_out, 1'b1);
        check("load_busy", tx_busy, 1'b1);
        check("sb_has_entry", exp_q.size() != 0, 1'b1);
        b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        expect_load = 1'b0;
        for (int i = 1; i <= F; i++) begin
          @(negedge clk);
          if (reset) break;
          check("frame_line", serial_out, frame_bit(b, (i - 1) / C));
          check("frame_busy", tx_busy, 1'b1);
          check("frame_done", tx_done, i == F);
          check("frame_no_deq", tx_deq, 1'b0);
          if (i == F) expect_load = !emptyTx;
        end
        if (reset) expect_load = 1'b0;
      end
    end
  end

  task automatic wait_deq(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_deq && n < budget);
    check("deq_seen", tx_deq, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || tx_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", n < budget, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, c0, b0, busy_cnt2, done_at;
    reset    = 1'b1;
    emptyTx  = 1'b1;
    tx_data  = 8'h00;
    emptyTx2 = 1'b1;
    tx_data2 = 8'h00;
    #3;
    check("rst_line", serial_out, 1'b1);
    check("rst_deq", tx_deq, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single frame 0xA5
    d0 = deq_cnt; c0 = done_cnt;
    push(8'hA5);
    wait_drain(200);
    check("a5_deq_count", deq_cnt - d0, 1);
    check("a5_done_count", done_cnt - c0, 1);
    check("a5_busy_len", last_run, 41);

    // Back-to-back 0x00 then 0xFF
    d0 = deq_cnt; c0 = done_cnt;
    push(8'h00);
    push(8'hFF);
    wait_drain(300);
    check("b2b_deq_count", deq_cnt - d0, 2);
    check("b2b_done_count", done_cnt - c0, 2);
    check("b2b_busy_len", last_run, 82);

    // Long idle with an empty FIFO
    d0 = deq_cnt; b0 = busy_cycles;
    repeat (100) @(posedge clk);
    #1;
    check("idle_deq_count", deq_cnt - d0, 0);
    check("idle_busy_cycles", busy_cycles - b0, 0);

    // Second byte arrives during the stop bit of the first
    d0 = deq_cnt;
    push(8'hC3);
    wait_deq(20);
    repeat (9 * C + 2) @(posedge clk);
    #1;
    push(8'h81);
    wait_drain(300);
    check("stop_join_deq_count", deq_cnt - d0, 2);
    check("stop_join_busy_len", last_run, 82);

    // Reset during data bit 3 of 0x3C
    push(8'h3C);
    wait_deq(20);
    repeat (4 * C + 2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_line", serial_out, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_done", tx_done, 1'b0);
    check("abort_deq", tx_deq, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = deq_cnt; c0 = done_cnt; b0 = busy_cycles;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - c0, 0);
    check("abort_no_deq", deq_cnt - d0, 0);
    check("abort_stays_idle", busy_cycles - b0, 0);

    // Randomized traffic with random arrival gaps
    for (int r = 0; r < 24; r++) begin
      int gap;
      gap = $urandom_range(0, 12 * C);
      repeat (gap) @(posedge clk);
      #1;
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
    end
    wait_drain(3000);
    check("sb_empty", exp_q.size(), 0);

    // Default rate instance, byte 0x55
    @(posedge clk);
    #1;
    emptyTx2 = 1'b0;
    tx_data2 = 8'h55;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_deq2 && n < 20);
    end
    check("r10_deq_seen", tx_deq2, 1'b1);
    fork
      begin
        @(posedge clk);
        #1;
        emptyTx2 = 1'b1;
      end
    join_none
    busy_cnt2 = tx_busy2 ? 1 : 0;
    done_at   = -1;
    for (int m = 1; m <= 100; m++) begin
      @(negedge clk);
      if ((m - 1) % 10 == 5) check("r10_midbit", serial_out2, frame_bit(8'h55, (m - 1) / 10));
      if (tx_busy2) busy_cnt2++;
      if (tx_done2) done_at = m;
    end
    @(negedge clk);
    check("r10_idle_after", tx_busy2, 1'b0);
    check("r10_busy_len", busy_cnt2, 101);
    check("r10_done_pos", done_at, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the encryption chip's serial link. It drains bytes from the transmit FIFO after the MCU enqueues processed data, and serializes each byte as a UART frame on serial_out: 1 start bit, 8 data bits LSB first, 1 stop bit. It also reports busy status for the status register and pulses once per completed frame.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period (min 2)
DATA_BITS, 8, data bits per frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
emptyTx  in  1  transmit FIFO empty flag
tx_data  in  DATA_BITS  transmit FIFO head word (first-word-fall-through, valid when !emptyTx)
tx_deq  out  1  one-cycle pop strobe to transmit FIFO
serial_out  out  1  UART line, idle high
tx_busy  out  1  high from LOAD through last STOP cycle
tx_done  out  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (async, active-high): state=IDLE, serial_out=1, tx_deq=0, tx_busy=0, tx_done=0, shift register=0, counters=0. Asserting reset mid-frame aborts the frame: serial_out returns to 1 immediately, and the byte already dequeued is lost.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: serial_out=1. If !emptyTx, go to LOAD next cycle. Otherwise stay.
- LOAD (1 cycle): tx_deq=1; latch tx_data into the shift register; clear the period and bit counters; go to START.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: serial_out=shift_reg[0]. At the end of each bit period, shift right by 1 and increment bit_cnt. After DATA_BITS periods, go to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles. tx_done=1 on the last cycle. Next state is LOAD if !emptyTx on that cycle, else IDLE. Back-to-back frames therefore have no idle gap beyond the 1-cycle LOAD, during which serial_out=1.
- Timing: the period counter counts 0..CLKS_PER_BIT-1, and a bit ends when count==CLKS_PER_BIT-1. One frame occupies 1 + (DATA_BITS+2)*CLKS_PER_BIT cycles, measured from LOAD to the last STOP cycle inclusive.
- Outputs: serial_out is registered and changes on the state/bit boundary clock edge. tx_deq is never asserted while emptyTx=1, and is never asserted outside LOAD.
- tx_busy = (state != IDLE).
- emptyTx toggling during a frame has no effect until the STOP-end decision.
- Counter widths: the period counter is $clog2(CLKS_PER_BIT) bits, and bit_cnt is $clog2(DATA_BITS+1) bits. Neither counter ever wraps past its terminal value.

Decomposition:
- Package uart_tx_pkg: the state enum typedef (IDLE, LOAD, START, DATA, STOP) and the frame constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- Sub-module tx_baud_timer: period counter with a clear input, an enable input, and a terminal-count output rollover_flag. Parameterized by CLKS_PER_BIT.
- The top level holds the FSM, the shift register and bit_cnt.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0xA5 -> tx_deq pulses once. serial_out reads 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. tx_done pulses on cycle 41 after LOAD. tx_busy is high for exactly 41 cycles.
- FIFO holds 0x00 then 0xFF -> two frames. One LOAD cycle (serial_out=1) separates the stop bit of frame 1 from the start bit of frame 2. tx_deq pulses exactly twice. tx_done pulses twice.
- emptyTx=1 held for 100 cycles -> serial_out=1, tx_deq=0, tx_busy=0 throughout.
- Reset asserted during DATA bit 3 of 0x3C -> serial_out=1 and tx_busy=0 in the same cycle. After release with emptyTx=1, the block stays idle and no tx_done is produced.
- emptyTx goes 0 during the STOP of frame 1 (second byte 0x81) -> the next state is LOAD and the second frame starts without passing through IDLE. The frame 2 line pattern is start, then 1,0,0,0,0,0,0,1, then stop.
- Default CLKS_PER_BIT=10, byte 0x55 -> frame is 101 cycles. Each bit is 10 cycles wide, checked at mid-bit sample points.
